ram_arbiter: RTL and testbench

// Shares one single-port synchronous data RAM between two masters: port 0 is the risc_v_core data port
// (ram_address/ram_w_data/read_write_ram_en), port 1 is the loader/debug master. One access per cycle.

---
 rtl/ram_arbiter_pkg.sv | 10 +
 rtl/ram_arbiter_rr_pick2.sv | 25 ++
 rtl/ram_arbiter.sv | 91 +++++++++
 tb/tb_ram_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encodings and port indices for the RAM arbiter.
package ram_arbiter_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin winner selection with a burst limit.
module rr_pick2
    import ram_arbiter_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int CW        = $clog2(BURST_MAX + 1)
) (
    input  logic          req0,
    input  logic          req1,
    input  arb_state_t    state,
    input  logic          last_owner,
    input  logic [CW-1:0] burst_cnt,
    output logic          win_valid,
    output logic          win_idx
);
    localparam logic [CW-1:0] BMAX = CW'(BURST_MAX);
    logic keep;
    assign keep      = burst_cnt < BMAX;
    assign win_valid = req0 | req1;
    // Under contention the current owner keeps the RAM until its burst runs out.
    assign win_idx   = !(req0 && req1)               ? req1  :
                       (state == ARB_OWN0 && keep)   ? PORT0 :
                       (state == ARB_OWN1 && keep)   ? PORT1 :
                       !last_owner;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two masters,
// round-robin with a burst limit; read data returns one cycle after the grant.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [WIDTH-1:0] m0_addr,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [WIDTH-1:0] m1_addr,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam int CW = $clog2(BURST_MAX + 1);

    arb_state_t    state, next_state;
    logic          last_owner, next_last;
    logic [CW-1:0] burst_cnt, next_cnt, sat_cnt;
    logic          win_valid, win_idx, gnt;
    logic          rv0_q, rv1_q;

    rr_pick2 #(.BURST_MAX(BURST_MAX), .CW(CW)) u_pick (
        .req0      (m0_req),
        .req1      (m1_req),
        .state     (state),
        .last_owner(last_owner),
        .burst_cnt (burst_cnt),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    assign gnt     = win_valid & !reset;
    assign sat_cnt = (&burst_cnt) ? burst_cnt : burst_cnt + CW'(1);

    always_comb begin
        next_state = ARB_IDLE;
        next_last  = last_owner;
        next_cnt   = '0;
        if (win_valid) begin
            next_state = win_idx ? ARB_OWN1 : ARB_OWN0;
            next_last  = win_idx;
            next_cnt   = (win_idx == last_owner && state != ARB_IDLE) ? sat_cnt : CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_owner <= PORT1;
            burst_cnt  <= '0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
        end else begin
            state      <= next_state;
            last_owner <= next_last;
            burst_cnt  <= next_cnt;
            rv0_q      <= m0_gnt & !m0_we;
            rv1_q      <= m1_gnt & !m1_we;
        end
    end

    assign m0_gnt    = gnt & (win_idx == PORT0);
    assign m1_gnt    = gnt & (win_idx == PORT1);
    assign mem_en    = gnt;
    assign mem_we    = gnt & (win_idx ? m1_we : m0_we);
    assign mem_addr  = !gnt ? '0 : win_idx ? m1_addr : m0_addr;
    assign mem_wdata = !gnt ? '0 : win_idx ? m1_wdata : m0_wdata;

    // Gating with reset drops a response whose read was accepted just before reset.
    assign m0_rvalid = rv0_q & !reset;
    assign m1_rvalid = rv1_q & !reset;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a small behavioural RAM.
module tb_ram_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [31:0] ram [0:255];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    ram_arbiter #(.WIDTH(32), .BURST_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Same request stream into a BURST_MAX=1 instance to see strict alternation.
    ram_arbiter #(.WIDTH(32), .BURST_MAX(1)) dut_alt (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(32'h0)
    );

    always @(posedge clock) begin
        if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= ram[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        m0_req = 1'b0;
        m1_req = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'hDEADBEEF;
        mem_rdata = 32'h0;
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0;  m1_wdata = 32'h0;

        // reset holds grants off, then first read goes through
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
            check("rst_mem_en", 32'(mem_en), 32'd0);
            check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("rd_m0_gnt", 32'(m0_gnt), 32'd1);
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_mem_addr", mem_addr, 32'h10);
        tick();
        m0_req = 1'b0;
        #1;
        check("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
        check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("idle_mem_en", 32'(mem_en), 32'd0);
        check("idle_mem_addr", mem_addr, 32'h0);
        tick();
        check("idle_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("idle_m0_rdata", m0_rdata, 32'h0);

        // contention: bursts of 4 vs strict alternation
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("burst_m0_gnt", 32'(m0_gnt), 32'(((i / 4) % 2) == 0));
            check("burst_m1_gnt", 32'(m1_gnt), 32'(((i / 4) % 2) == 1));
            check("alt_m0_gnt", 32'(a_m0_gnt), 32'((i % 2) == 0));
            check("alt_m1_gnt", 32'(a_m1_gnt), 32'((i % 2) == 1));
            tick();
        end

        // lone m1 is never cut off; m0 joining after a long burst wins at once
        do_reset();
        m1_req = 1'b1; m1_addr = 32'h8;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("solo_m1_gnt", 32'(m1_gnt), 32'd1);
            tick();
        end
        m0_req = 1'b1;
        #1;
        check("join_m0_gnt", 32'(m0_gnt), 32'd1);
        check("join_m1_gnt", 32'(m1_gnt), 32'd0);
        check("join_mem_addr", mem_addr, 32'h0);
        tick();
        m0_req = 1'b0;
        #1;
        check("drop_m1_gnt", 32'(m1_gnt), 32'd1);
        tick();

        // same-cycle write by m0 and read by m1 of address 0x20
        do_reset();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h55;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
        #1;
        check("wr_m0_gnt", 32'(m0_gnt), 32'd1);
        check("wr_m1_gnt", 32'(m1_gnt), 32'd0);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_wdata", mem_wdata, 32'h55);
        tick();
        m0_req = 1'b0; m0_we = 1'b0;
        #1;
        check("wr_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rd2_m1_gnt", 32'(m1_gnt), 32'd1);
        tick();
        m1_req = 1'b0;
        #1;
        check("rd2_m1_rvalid", 32'(m1_rvalid), 32'd1);
        check("rd2_m1_rdata", m1_rdata, 32'h55);

        // reset right after an accepted read discards the response
        do_reset();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10;
        #1;
        check("rr_m1_gnt", 32'(m1_gnt), 32'd1);
        tick();
        reset = 1'b1;
        #1;
        check("rr_m1_rvalid_n1", 32'(m1_rvalid), 32'd0);
        check("rr_m1_gnt_rst", 32'(m1_gnt), 32'd0);
        check("rr_mem_en_rst", 32'(mem_en), 32'd0);
        m1_req = 1'b0;
        tick();
        check("rr_m1_rvalid_n2", 32'(m1_rvalid), 32'd0);
        reset = 1'b0;
        tick();
        check("rr_state_idle", 32'(dut.state), 32'd0);
        check("rr_m1_rvalid_n3", 32'(m1_rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
